// File: rtl/led_key_pkg.sv
// Shared types and helpers for the LED/key controller.
package led_key_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    // Press sequence: OFF -> ON -> SLOW -> FAST -> OFF.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:  return MODE_ON;
            MODE_ON:   return MODE_SLOW;
            MODE_SLOW: return MODE_FAST;
            default:   return MODE_OFF;
        endcase
    endfunction

    function automatic logic is_blink(input mode_t m);
        return (m == MODE_SLOW) || (m == MODE_FAST);
    endfunction

endpackage

// File: rtl/key_filter.sv
// Key front end: two-flop synchronizer, level debounce and press-event pulse.
module key_filter #(
    parameter int unsigned CNT_DEBOUNCE = 999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag
);

    localparam int unsigned DB_W = (CNT_DEBOUNCE < 1) ? 1 : $clog2(CNT_DEBOUNCE + 1);
    localparam logic [DB_W-1:0] DB_TC = DB_W'(CNT_DEBOUNCE);

    logic            key_meta;
    logic            key_sync;
    logic            key_stable;
    logic            key_stable_d;
    logic [DB_W-1:0] db_cnt;

    // Bring the raw key into the clock domain; idle level (released) is 1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_sync <= key_meta;
        end
    end

    // Accept a new level only after it has held for CNT_DEBOUNCE+1 cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_stable <= 1'b1;
            db_cnt     <= '0;
        end else if (key_sync == key_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_TC) begin
            key_stable <= key_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Pulse once on the debounced falling edge (press); releases are silent.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_stable_d <= 1'b1;
            key_flag     <= 1'b0;
        end else begin
            key_stable_d <= key_stable;
            key_flag     <= key_stable_d & ~key_stable;
        end
    end

endmodule

// File: rtl/led_key_ctrl.sv
// Key-driven LED mode sequencer with blink generator and registered LED drive.
//
// state     | meaning
// ----------+-------------------------------------------
// MODE_OFF  | LED dark
// MODE_ON   | LED lit continuously
// MODE_SLOW | LED toggles every CNT_SLOW+1 cycles
// MODE_FAST | LED toggles every CNT_FAST+1 cycles
module led_key_ctrl
    import led_key_pkg::*;
#(
    parameter int unsigned CNT_DEBOUNCE = 999_999,
    parameter int unsigned CNT_SLOW     = 24_999_999,
    parameter int unsigned CNT_FAST     = 4_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_in,
    output logic       key_flag,
    output logic [1:0] mode,
    output logic       led_out
);

    localparam int unsigned CNT_BLINK_MAX = (CNT_SLOW > CNT_FAST) ? CNT_SLOW : CNT_FAST;
    localparam int unsigned BL_W = (CNT_BLINK_MAX < 1) ? 1 : $clog2(CNT_BLINK_MAX + 1);
    localparam logic [BL_W-1:0] TC_SLOW = BL_W'(CNT_SLOW);
    localparam logic [BL_W-1:0] TC_FAST = BL_W'(CNT_FAST);

    mode_t           mode_q;
    mode_t           mode_d;
    logic [BL_W-1:0] blink_cnt;
    logic [BL_W-1:0] blink_tc;
    logic            blink_lit;

    key_filter #(
        .CNT_DEBOUNCE (CNT_DEBOUNCE)
    ) u_key_filter (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_flag  (key_flag)
    );

    // Mode state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Next mode: step once per press event, otherwise hold.
    always_comb begin
        mode_d = mode_q;
        if (key_flag) begin
            mode_d = next_mode(mode_q);
        end
    end

    assign mode     = mode_q;
    assign blink_tc = (mode_q == MODE_SLOW) ? TC_SLOW : TC_FAST;

    // Half-period blink timer; a mode change wins over a same-cycle terminal
    // count so every blink mode starts in its lit phase.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt <= '0;
            blink_lit <= 1'b0;
        end else if (key_flag) begin
            blink_cnt <= '0;
            blink_lit <= is_blink(mode_d);
        end else if (!is_blink(mode_q)) begin
            blink_cnt <= '0;
            blink_lit <= 1'b0;
        end else if (blink_cnt == blink_tc) begin
            blink_cnt <= '0;
            blink_lit <= ~blink_lit;
        end else begin
            blink_cnt <= blink_cnt + BL_W'(1);
        end
    end

    // Registered LED drive, active low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_out <= 1'b1;
        end else begin
            case (mode_q)
                MODE_OFF: led_out <= 1'b1;
                MODE_ON:  led_out <= 1'b0;
                default:  led_out <= ~blink_lit;
            endcase
        end
    end

endmodule
